// File: rtl/clk_gen_downsampler.sv
// clk_gen_downsampler: programmable 50%-duty divider for the raw oscillator clock.
// Latency: clk_out/edge_pulse are registered and change one clk edge after terminal count.
// Backpressure: cfg_ready is low while a divide value is pending. The value is applied at the next clk_out falling edge.
//
// Ports:
//   clk        raw oscillator clock (only clock in the block)
//   reset      asynchronous, active-high reset
//   cfg_v      configuration valid
//   cfg_data   requested divide value D (period = 2*(D+1) clk cycles)
//   cfg_ready  high when no divide value is pending
//   clk_out    divided clock
//   edge_pulse one-cycle pulse in the cycle where clk_out rises
//   div_active divide value currently in use
//   bypass     (only when CLK_GEN_DS_BYPASS_EN is defined) selects raw clk onto clk_out
//
// Optional feature macro: CLK_GEN_DS_BYPASS_EN adds the bypass input and a glitch-free clock select.
module clk_gen_downsampler #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef CLK_GEN_DS_BYPASS_EN
  input  logic             bypass,
`endif
  input  logic             cfg_v,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             edge_pulse,
  output logic [WIDTH-1:0] div_active
);

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] pending_data;
  logic             pending_v;
  logic             clk_div;
  logic             terminal;
  logic             pulse_gate;

  assign terminal  = (counter == div_active);
  assign cfg_ready = ~pending_v;

`ifdef CLK_GEN_DS_BYPASS_EN
  assign pulse_gate = bypass;
`else
  assign pulse_gate = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter      <= '0;
      clk_div      <= 1'b0;
      edge_pulse   <= 1'b0;
      div_active   <= WIDTH'(DEFAULT_DIV);
      pending_v    <= 1'b0;
      pending_data <= '0;
    end else begin
      // The counter stops at div_active and restarts from 0, so it never wraps
      // and every phase lasts exactly div_active+1 cycles.
      if (terminal) begin
        counter <= '0;
        clk_div <= ~clk_div;
        // Swap the ratio only when a high phase ends. The next low phase then
        // runs entirely at the new ratio, so no runt phase is produced.
        if (clk_div && pending_v) begin
          div_active <= pending_data;
          pending_v  <= 1'b0;
        end
      end else begin
        counter <= counter + 1'b1;
      end

      // Transfer and apply are mutually exclusive: a transfer needs
      // pending_v==0 and an apply needs pending_v==1.
      if (cfg_v && cfg_ready) begin
        pending_data <= cfg_data;
        pending_v    <= 1'b1;
      end

      edge_pulse <= terminal && !clk_div && !pulse_gate;
    end
  end

`ifdef CLK_GEN_DS_BYPASS_EN
  // The select updates on the clk falling edge and only while clk_div is low.
  // clk_div changes only on rising edges, so both sources are low for the
  // whole half-cycle around the switch point.
  logic sel_raw;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      sel_raw <= 1'b0;
    end else if (!clk_div) begin
      sel_raw <= bypass;
    end
  end

  assign clk_out = sel_raw ? clk : clk_div;
`else
  assign clk_out = clk_div;
`endif

endmodule

// File: tb/tb_clk_gen_downsampler.sv
// Testbench for clk_gen_downsampler (default build, DEFAULT_DIV=0).
// Stimulus pushes expected clk_out phases (level and length in clk cycles) into a queue.
// A monitor measures each completed phase and compares it against the queue head.
module tb_clk_gen_downsampler;

  logic       clk;
  logic       reset;
  logic       cfg_v;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       clk_out;
  logic       edge_pulse;
  logic [7:0] div_active;

  clk_gen_downsampler #(.WIDTH(8), .DEFAULT_DIV(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_v     (cfg_v),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .edge_pulse(edge_pulse),
    .div_active(div_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        lvl;
    logic [15:0] len;
  } phase_t;

  phase_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     ecnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ph(input logic lvl, input int len);
    phase_t p;
    p.lvl = lvl;
    p.len = 16'(len);
    exp_q.push_back(p);
  endtask

  // Edge counter: edge k is the k-th rising clk edge after reset release.
  always @(posedge clk) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  task automatic at_edge(input int n);
    while (ecnt != n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: samples on the falling clk edge, measures phase lengths and
  // checks edge_pulse against the observed rising transition.
  logic mon_prev;
  logic mon_started;
  int   mon_run;

  always @(negedge clk) begin
    phase_t e;
    if (reset) begin
      mon_prev    = 1'b0;
      mon_started = 1'b0;
      mon_run     = 0;
    end else begin
      check("edge_pulse", 32'(edge_pulse), 32'(clk_out && !mon_prev));
      if (clk_out != mon_prev) begin
        if (mon_started) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL phase_extra: got level %0d len %0d, expected no phase", mon_prev, mon_run);
          end else begin
            e = exp_q.pop_front();
            check("phase_lvl", 32'(mon_prev), 32'(e.lvl));
            check("phase_len", 32'(mon_run), 32'(e.len));
          end
        end
        mon_started = 1'b1;
        mon_run     = 1;
      end else begin
        mon_run++;
      end
      mon_prev = clk_out;
    end
  end

  initial begin
    reset    = 1'b1;
    cfg_v    = 1'b0;
    cfg_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_edge_pulse", 32'(edge_pulse), 32'd0);
    check("rst_div_active", 32'(div_active), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Expected phases from the first clk_out rise up to the mid-phase reset.
    for (int i = 0; i < 11; i++) push_ph((i % 2) == 0, 1);   // D=0, edges 1..12
    push_ph(1'b0, 4); push_ph(1'b1, 4);                      // D=3
    push_ph(1'b0, 2); push_ph(1'b1, 2);                      // D=1
    push_ph(1'b0, 2); push_ph(1'b1, 2);
    push_ph(1'b0, 6); push_ph(1'b1, 6);                      // D=5
    push_ph(1'b0, 8); push_ph(1'b1, 8);                      // D=7, period 16
    push_ph(1'b0, 4);                                        // D=3, then reset mid-high

    reset = 1'b0;

    at_edge(10);
    check("d0_clk_out", 32'(clk_out), 32'd0);
    check("d0_div_active", 32'(div_active), 32'd0);
    check("d0_cfg_ready", 32'(cfg_ready), 32'd1);
    cfg_v = 1'b1; cfg_data = 8'd3;

    at_edge(11);
    check("cfg3_ready_low", 32'(cfg_ready), 32'd0);
    check("cfg3_clk_out", 32'(clk_out), 32'd1);
    cfg_v = 1'b0; cfg_data = 8'hAA;

    at_edge(12);
    check("cfg3_applied", 32'(div_active), 32'd3);
    check("cfg3_clk_low", 32'(clk_out), 32'd0);

    // Mid-high-phase request for D=1: the running high phase keeps 4 cycles.
    at_edge(16);
    cfg_v = 1'b1; cfg_data = 8'd1;
    at_edge(17);
    check("cfg1_ready_low", 32'(cfg_ready), 32'd0);
    cfg_v = 1'b0;
    at_edge(19);
    check("cfg1_not_yet", 32'(div_active), 32'd3);
    at_edge(20);
    check("cfg1_applied", 32'(div_active), 32'd1);

    // Back-to-back 5 then 7 with cfg_v held high.
    at_edge(24);
    cfg_v = 1'b1; cfg_data = 8'd5;
    at_edge(25);
    check("cfg5_ready_low", 32'(cfg_ready), 32'd0);
    cfg_data = 8'd7;
    at_edge(27);
    check("cfg5_wait_div", 32'(div_active), 32'd1);
    check("cfg5_wait_ready", 32'(cfg_ready), 32'd0);
    at_edge(28);
    check("cfg5_applied", 32'(div_active), 32'd5);
    check("cfg5_ready_back", 32'(cfg_ready), 32'd1);
    at_edge(29);
    check("cfg7_ready_low", 32'(cfg_ready), 32'd0);
    cfg_v = 1'b0;
    at_edge(40);
    check("cfg7_applied", 32'(div_active), 32'd7);

    // Back to D=3, leave a value pending, then reset mid high phase.
    at_edge(48);
    cfg_v = 1'b1; cfg_data = 8'd3;
    at_edge(49);
    cfg_v = 1'b0;
    at_edge(56);
    check("cfg3b_applied", 32'(div_active), 32'd3);
    at_edge(60);
    check("pre_rst_rise", 32'(clk_out), 32'd1);
    cfg_v = 1'b1; cfg_data = 8'd9;
    at_edge(61);
    cfg_v = 1'b0;
    check("pend9_ready_low", 32'(cfg_ready), 32'd0);
    at_edge(62);
    check("pre_rst_high", 32'(clk_out), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_clk_out", 32'(clk_out), 32'd0);
    check("async_div_active", 32'(div_active), 32'd0);
    check("async_cfg_ready", 32'(cfg_ready), 32'd1);
    check("async_edge_pulse", 32'(edge_pulse), 32'd0);
    check("queue_before_rst", 32'(exp_q.size()), 32'd0);

    // After release the divider must run at D=0; the pending 9 was discarded.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) push_ph((i % 2) == 0, 1);
    reset = 1'b0;
    at_edge(8);
    check("post_rst_div", 32'(div_active), 32'd0);
    check("post_rst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clk_gen_downsampler.md
Name: clk_gen_downsampler

Overview:
Programmable clock divider that sits directly downstream of the clock-generator oscillator loop. It consumes the raw ring-oscillator clock and produces a slower, 50%-duty clock for the GCD core. The divide ratio is loaded through a small valid/ready configuration port. A new ratio is applied only on a divided-clock boundary, so the output never glitches or produces a runt pulse.

Parameters:
WIDTH, 8, width of the divide-control value and the internal counter
DEFAULT_DIV, 0, divide value loaded at reset (0 means divide-by-2)

Ports:
clk  in  1  raw oscillator clock (oscillator loop output); only clock in the block
reset  in  1  asynchronous, active-high reset
cfg_v  in  1  configuration valid
cfg_data  in  WIDTH  requested divide value D
cfg_ready  out  1  high when the block can accept a new cfg_data
clk_out  out  1  divided clock, registered, period 2*(D+1) clk cycles
edge_pulse  out  1  one-cycle pulse in the clk cycle where clk_out rises
div_active  out  WIDTH  divide value currently in use

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: counter=0, clk_out=0, edge_pulse=0, div_active=DEFAULT_DIV, pending_v=0, pending_data=0, cfg_ready=1.
- Reset assertion forces all state to its reset value immediately, even mid-period. clk_out drops low asynchronously.
- Counter operation, on each clk rising edge (not in reset):
  - If counter==div_active (terminal count): counter<=0 and clk_out<=~clk_out.
  - Otherwise: counter<=counter+1.
  - The counter never exceeds div_active, so it cannot wrap.
- Result: clk_out toggles every D+1 cycles, giving period 2*(D+1) and an exact 50% duty for every D.
- D=0: clk_out toggles every cycle (divide-by-2).
- D=2^WIDTH-1: divide-by-2^(WIDTH+1). No overflow.
- First rising edge of clk_out after reset deassertion occurs on the (DEFAULT_DIV+1)th clk edge.
- edge_pulse is registered. It is 1 in exactly the cycle where clk_out goes from 0 to 1, and 0 otherwise.
- Config handshake: a transfer occurs when cfg_v && cfg_ready at a clk edge.
  - On transfer: pending_data<=cfg_data, pending_v<=1, cfg_ready<=0.
  - cfg_ready = ~pending_v.
  - cfg_data is ignored when no transfer occurs.
- Apply rule: a pending value is applied only at a terminal count where clk_out is 1 and is about to fall.
  - At that edge: div_active<=pending_data, pending_v<=0, counter<=0.
  - The new ratio therefore takes effect at the start of a full low phase.
  - No phase is ever shorter than min(old, new) D+1 cycles.
- Simultaneous transfer and apply in the same cycle cannot occur, because cfg_ready is 0 while a value is pending.
- A transfer accepted in the cycle of a falling-edge terminal count is held until the next falling-edge terminal count.
- Writing the same value as div_active still goes through the handshake and apply rule. Output is unchanged.

Optional Feature:
- Macro: CLK_GEN_DS_BYPASS_EN.
- Defined:
  - Adds input bypass (1 bit).
  - When bypass=1, clk_out = clk via a single glitch-free select that switches only while both the raw and divided clocks are low.
  - The counter, handshake and div_active keep running.
  - edge_pulse is held at 0 while bypass=1.
- Not defined:
  - No bypass port.
  - clk_out is always the registered divided clock.

Test Plan:
- Reset with DEFAULT_DIV=0, release, run 10 clk -> clk_out pattern 1,0,1,0,...; edge_pulse high on every second cycle; div_active=0.
- cfg_v=1, cfg_data=3 -> cfg_ready falls the next cycle; new ratio applies at the next falling edge of clk_out. Afterwards clk_out is high 4, low 4 (period 8) and div_active=3.
- With D=3 running, issue cfg_data=1 mid-high-phase -> current high phase completes at 4 cycles; subsequent phases are 2 cycles each; no runt pulse.
- Hold cfg_v=1 with two back-to-back values 5 and 7 -> only 5 is accepted; 7 is accepted after cfg_ready returns high; the final period is 16.
- Assert reset asynchronously mid-phase (D=3, counter=2, clk_out=1) -> clk_out=0 immediately; after release, div_active=DEFAULT_DIV and pending is cleared.
- With CLK_GEN_DS_BYPASS_EN defined and bypass=1 -> clk_out follows clk; edge_pulse=0; deassert bypass -> divided clock resumes with no glitch.
